// File: rtl/clk_divide_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package clk_divide_pkg;

  localparam int DEF_DIV_DEFAULT = 1_000_000;
  localparam int MAX_NCH         = 16;

  typedef logic [$clog2(MAX_NCH)-1:0] chan_idx_t;

  // Channel-select width; a single channel still needs a one-bit select.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_divide_chan.sv
// One divider channel: period counter, shadowed div/high configuration and
// registered clk_out/tick/pend outputs.
module clk_divide_chan
  import clk_divide_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] div,
  input  logic [WIDTH-1:0] high,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEF_DIV / 2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] high_act;
  logic [WIDTH-1:0] div_pnd;
  logic [WIDTH-1:0] high_pnd;
  logic [WIDTH-1:0] div_eff;
  logic             at_wrap;
  logic             apply;

  // A zero divisor behaves like one: the channel ticks every cycle.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    div_eff = (div_act == '0) ? WIDTH'(1) : div_act;
    at_wrap = en && (cnt == div_eff - WIDTH'(1));
    apply   = sync || !en || at_wrap;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_act  <= RST_DIV;
      high_act <= RST_HIGH;
      div_pnd  <= RST_DIV;
      high_pnd <= RST_HIGH;
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      clk_out <= en && (cnt < high_act);
      tick    <= en && (cnt == '0);
      if (apply) begin
        // Boundary: restart the period on the newest configuration.
        cnt  <= '0;
        pend <= 1'b0;
        if (wr) begin
          div_act  <= div;
          high_act <= high;
          div_pnd  <= div;
          high_pnd <= high;
        end else begin
          div_act  <= div_pnd;
          high_act <= high_pnd;
        end
      end else begin
        cnt <= cnt + WIDTH'(1);
        if (wr) begin
          div_pnd  <= div;
          high_pnd <= high;
          pend     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_divide_multi.sv
// Multi-channel runtime-programmable clock-enable generator: decodes
// configuration writes and instantiates one divider per channel.
module clk_divide_multi
  import clk_divide_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIDTH   = 24,
  parameter int DEF_DIV = DEF_DIV_DEFAULT,
  parameter int CH_W    = ch_width(NCH)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  logic [31:0]    ch_idx;
  logic           in_range;
  logic [NCH-1:0] wr;

  // Widened index so out-of-range selects never alias onto a real channel.
  assign ch_idx   = 32'(cfg_ch);
  assign in_range = ch_idx < 32'(NCH);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr[i] = cfg_we && in_range && (ch_idx == 32'(i));

    clk_divide_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr[i]),
      .div     (cfg_div),
      .high    (cfg_high),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_divide_multi.sv
// Scoreboard bench for clk_divide_multi: directed phases push cycle-tagged
// expectations, a negedge monitor compares them against the outputs.
module tb_clk_divide_multi;

  localparam int NCH     = 4;
  localparam int WIDTH   = 8;
  localparam int DEF_DIV = 10;
  localparam int CH_W    = 3;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             sync;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pend;

  clk_divide_multi #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .DEF_DIV (DEF_DIV),
    .CH_W    (CH_W)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .clk_out  (clk_out),
    .tick     (tick),
    .pend     (pend)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int             cyc;
    string          name;
    logic [NCH-1:0] co;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] pd;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation tagged with the current cycle.
  always @(negedge clk_in) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check({sb[i].name, " clk_out"}, clk_out, sb[i].co);
        check({sb[i].name, " tick"},    tick,    sb[i].tk);
        check({sb[i].name, " pend"},    pend,    sb[i].pd);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int d, input string name,
                           input logic [NCH-1:0] co, input logic [NCH-1:0] tk,
                           input logic [NCH-1:0] pd);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = name;
    e.co   = co;
    e.tk   = tk;
    e.pd   = pd;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cfg(input int ch, input int dv, input int hi);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_div  = WIDTH'(dv);
    cfg_high = WIDTH'(hi);
  endtask

  task automatic quiesce();
    en     = '0;
    sync   = 1'b0;
    cfg_we = 1'b0;
    expect_at(1, "quiesce", '0, '0, '0);
    step();
  endtask

  initial begin
    logic [NCH-1:0] co, tk, pd;
    int k;

    rst = 1'b1; en = '0; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_high = '0;

    // Reset state
    step();
    expect_at(0, "reset", '0, '0, '0);
    expect_at(1, "reset", '0, '0, '0);
    step();
    rst = 1'b0;
    expect_at(1, "post_reset", '0, '0, '0);
    step();

    // A: default 10-cycle period, 5 high, first tick one cycle after enable
    for (int j = 0; j < 20; j++) begin
      k = j % 10; co = '0; tk = '0;
      co[0] = (k < 5); tk[0] = (k == 0);
      expect_at(j + 1, "a_default", co, tk, '0);
    end
    en = 4'b0001;
    repeat (20) step();
    quiesce();

    // B: ch1 write mid-period is held pending until the wrap
    for (int j = 0; j < 23; j++) begin
      co = '0; tk = '0; pd = '0;
      if (j < 10) begin
        co[1] = (j < 5); tk[1] = (j == 0); pd[1] = (j >= 3 && j <= 8);
      end else begin
        k = (j - 10) % 6;
        co[1] = (k < 2); tk[1] = (k == 0);
      end
      expect_at(j + 1, "b_pending", co, tk, pd);
    end
    for (int s = 0; s < 23; s++) begin
      en = 4'b0010; cfg_we = 1'b0;
      if (s == 3) cfg(1, 6, 2);
      step();
    end
    quiesce();

    // C: write on the wrap edge bypasses; two writes before wrap, last wins
    for (int j = 0; j < 24; j++) begin
      co = '0; tk = '0; pd = '0;
      if (j < 6) begin
        k = j; co[1] = (k < 2);
      end else if (j < 12) begin
        k = (j - 6) % 3; co[1] = (k < 1);
      end else begin
        k = (j - 12) % 5; co[1] = (k < 3);
      end
      tk[1] = (k == 0);
      pd[1] = (j == 9 || j == 10);
      expect_at(j + 1, "c_bypass", co, tk, pd);
    end
    for (int s = 0; s < 24; s++) begin
      en = 4'b0010; cfg_we = 1'b0;
      if (s == 5)  cfg(1, 3, 1);
      if (s == 9)  cfg(1, 4, 2);
      if (s == 10) cfg(1, 5, 3);
      step();
    end
    quiesce();

    // D: edge cases, written while disabled; cfg_ch=5 must be ignored
    for (int j = 0; j < 5; j++) expect_at(j + 1, "d_setup", '0, '0, '0);
    for (int s = 0; s < 5; s++) begin
      en = '0; cfg_we = 1'b0;
      case (s)
        0: cfg(0, 0, 0);
        1: cfg(1, 1, 1);
        2: cfg(2, 5, 7);
        3: cfg(3, 4, 0);
        default: cfg(5, 2, 1);
      endcase
      step();
    end
    for (int j = 0; j < 12; j++) begin
      co = '0; tk = '0;
      tk[0] = 1'b1;
      co[1] = 1'b1; tk[1] = 1'b1;
      co[2] = 1'b1; tk[2] = ((j % 5) == 0);
      tk[3] = ((j % 4) == 0);
      expect_at(j + 1, "d_edges", co, tk, '0);
    end
    for (int s = 0; s < 12; s++) begin
      en = 4'b1111; cfg_we = 1'b0;
      if (s == 3) cfg(5, 2, 1);
      step();
    end
    quiesce();

    // E: out-of-phase channels realigned by sync, pending configs applied
    expect_at(1, "e_setup", '0, '0, '0);
    expect_at(2, "e_setup", '0, '0, '0);
    cfg(0, 4, 2); step();
    cfg(1, 6, 3); step();
    for (int j = 0; j < 17; j++) begin
      co = '0; tk = '0; pd = '0;
      if (j <= 6) begin
        k = j % 4; co[0] = (k < 2); tk[0] = (k == 0);
      end else begin
        k = (j - 7) % 3; co[0] = (k == 0); tk[0] = (k == 0);
      end
      if (j >= 2 && j <= 6) begin
        k = j - 2; co[1] = (k < 3); tk[1] = (k == 0);
      end else if (j >= 7) begin
        k = (j - 7) % 2; co[1] = (k == 0); tk[1] = (k == 0);
      end
      pd[0] = (j == 4 || j == 5);
      pd[1] = (j == 5);
      expect_at(j + 1, "e_sync", co, tk, pd);
    end
    for (int s = 0; s < 17; s++) begin
      en = (s < 2) ? 4'b0001 : 4'b0011;
      cfg_we = 1'b0;
      sync = (s == 6);
      if (s == 4) cfg(0, 3, 1);
      if (s == 5) cfg(1, 2, 1);
      step();
    end
    quiesce();

    // F: reset mid-count with a pending write; default period resumes
    for (int j = 0; j < 4; j++) begin
      co = '0; tk = '0; pd = '0;
      k = j % 3; co[0] = (k < 1); tk[0] = (k == 0); pd[0] = (j == 3);
      expect_at(j + 1, "f_prerst", co, tk, pd);
    end
    for (int s = 0; s < 5; s++) begin
      en = 4'b0001; cfg_we = 1'b0;
      if (s == 3) cfg(0, 7, 3);
      step();
    end
    rst = 1'b1;
    for (int d = 0; d < 4; d++) expect_at(d, "f_in_reset", '0, '0, '0);
    repeat (3) step();
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      k = j % 10; co = '0; tk = '0;
      co[0] = (k < 5); tk[0] = (k == 0);
      expect_at(j + 1, "f_resume", co, tk, '0);
    end
    repeat (12) step();

    // Drain the scoreboard within a bounded number of cycles
    for (int b = 0; b < 50 && sb.size() > 0; b++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
